grayscale_frame_packer: RTL and testbench



---
 rtl/grayscale_pkg.sv | 22 ++
 rtl/rgb565Grayscale.sv | 19 +
 rtl/grayscale_frame_packer.sv | 136 +++++++++++++
 tb/tb_grayscale_frame_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// Shared constants and state encoding for the grayscale frame packer.
package grayscale_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned GRAY_W_R   = 54;
  localparam int unsigned GRAY_W_G   = 183;
  localparam int unsigned GRAY_W_B   = 19;
  localparam int unsigned GRAY_SHIFT = 8;

  localparam int unsigned GRAY_LANES = 4;
  localparam int unsigned GRAY_BITS  = 8;
  localparam int unsigned PIXEL_BITS = 16;
  localparam int unsigned WORD_BITS  = GRAY_LANES * GRAY_BITS;
  localparam int unsigned IDX_W      = $clog2(GRAY_LANES);

endpackage

// File: rtl/rgb565Grayscale.sv
// Combinational RGB565 to 8-bit grayscale converter (weighted sum, truncating shift).
module rgb565Grayscale
  import grayscale_pkg::*;
(
  input  logic [PIXEL_BITS-1:0] pixel,
  output logic [GRAY_BITS-1:0]  gray
);

  logic [15:0] weighted;

  // Weighted channel sum; max 13792 so 16 bits never overflow.
  always_comb begin
    weighted = 16'(GRAY_W_R) * 16'(pixel[15:11])
             + 16'(GRAY_W_G) * 16'(pixel[10:5])
             + 16'(GRAY_W_B) * 16'(pixel[4:0]);
    gray     = 8'(weighted >> GRAY_SHIFT);
  end

endmodule

// File: rtl/grayscale_frame_packer.sv
// Frame controller: converts a counted RGB565 stream to gray and packs 4 bytes per word.
module grayscale_frame_packer
  import grayscale_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT_WIDTH = 20
) (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic                         start,
  input  logic [PIXEL_COUNT_WIDTH-1:0] pixelCount,
  output logic                         busy,
  output logic                         done,
  input  logic                         pixelValid,
  input  logic [PIXEL_BITS-1:0]        pixelData,
  output logic                         pixelReady,
  output logic                         wordValid,
  output logic [WORD_BITS-1:0]         wordData,
  output logic                         wordLast,
  input  logic                         wordReady
);

  state_t                       state, state_next;
  logic [PIXEL_COUNT_WIDTH-1:0] remaining;
  logic [IDX_W-1:0]             idx;
  logic [GRAY_BITS-1:0]         lanes [GRAY_LANES-1];
  logic [GRAY_BITS-1:0]         gray;

  logic out_free;
  logic accept;
  logic last_pixel;
  logic idx_full;
  logic start_frame;
  logic load_full;
  logic load_flush;
  logic done_set;

  rgb565Grayscale u_conv (
    .pixel (pixelData),
    .gray  (gray)
  );

  assign out_free   = !wordValid || wordReady;
  assign idx_full   = (idx == IDX_W'(GRAY_LANES - 1));
  assign last_pixel = (remaining == PIXEL_COUNT_WIDTH'(1));
  assign pixelReady = (state == RUN) && (remaining != '0) && (!idx_full || out_free);
  assign accept     = pixelValid && pixelReady;

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    load_full   = 1'b0;
    load_flush  = 1'b0;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_next  = (pixelCount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          load_full = idx_full;
          if (last_pixel) state_next = idx_full ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_flush = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Any word held here is the last one; an empty frame has none.
        if (out_free) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame counters, lane staging and the output word register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      idx       <= '0;
      wordValid <= 1'b0;
      wordLast  <= 1'b0;
      wordData  <= '0;
      for (int unsigned i = 0; i < GRAY_LANES - 1; i++) lanes[i] <= '0;
    end else begin
      done <= done_set;
      if (start_frame)   busy <= 1'b1;
      else if (done_set) busy <= 1'b0;

      if (start_frame) begin
        remaining <= pixelCount;
        idx       <= '0;
        for (int unsigned i = 0; i < GRAY_LANES - 1; i++) lanes[i] <= '0;
      end else if (accept) begin
        remaining <= remaining - PIXEL_COUNT_WIDTH'(1);
        idx       <= idx + IDX_W'(1);
        // The fourth byte bypasses staging; cleared lanes give zero fill on flush.
        for (int unsigned i = 0; i < GRAY_LANES - 1; i++) begin
          if (idx_full)                lanes[i] <= '0;
          else if (idx == IDX_W'(i))   lanes[i] <= gray;
        end
      end

      if (load_full) begin
        wordData  <= {lanes[0], lanes[1], lanes[2], gray};
        wordValid <= 1'b1;
        wordLast  <= last_pixel;
      end else if (load_flush) begin
        wordData  <= {lanes[0], lanes[1], lanes[2], 8'h00};
        wordValid <= 1'b1;
        wordLast  <= 1'b1;
      end else if (wordValid && wordReady) begin
        wordValid <= 1'b0;
        wordLast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grayscale_frame_packer.sv
// Directed self-checking bench for grayscale_frame_packer.
module tb_grayscale_frame_packer;

  logic        clock;
  logic        nReset;
  logic        start;
  logic [19:0] pixelCount;
  logic        busy;
  logic        done;
  logic        pixelValid;
  logic [15:0] pixelData;
  logic        pixelReady;
  logic        wordValid;
  logic [31:0] wordData;
  logic        wordLast;
  logic        wordReady;

  int n_checks = 0;
  int n_fail   = 0;

  grayscale_frame_packer #(.PIXEL_COUNT_WIDTH(20)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .start      (start),
    .pixelCount (pixelCount),
    .busy       (busy),
    .done       (done),
    .pixelValid (pixelValid),
    .pixelData  (pixelData),
    .pixelReady (pixelReady),
    .wordValid  (wordValid),
    .wordData   (wordData),
    .wordLast   (wordLast),
    .wordReady  (wordReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one pixel and advance past the edge that accepts it (bounded wait).
  task automatic push(input logic [15:0] d);
    logic got;
    got = 1'b0;
    pixelValid = 1'b1;
    pixelData  = d;
    for (int n = 0; n < 50 && !got; n++) begin
      #1;
      if (pixelReady) got = 1'b1;
      tick();
    end
    check("push_accept", 32'(got), 32'd1);
  endtask

  task automatic pulse_start(input logic [19:0] cnt);
    start      = 1'b1;
    pixelCount = cnt;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    nReset     = 1'b0;
    start      = 1'b0;
    pixelCount = '0;
    pixelValid = 1'b0;
    pixelData  = '0;
    wordReady  = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pixready", 32'(pixelReady), 32'd0);
    check("rst_wvalid", 32'(wordValid), 32'd0);
    check("rst_wlast", 32'(wordLast), 32'd0);
    check("rst_wdata", wordData, 32'h0);
    tick();
    tick();
    nReset = 1'b1;
    tick();

    // Full word: one of each primary plus white.
    wordReady = 1'b1;
    pulse_start(20'd4);
    #1;
    check("t1_busy", 32'(busy), 32'd1);
    push(16'hFFFF);
    push(16'hF800);
    push(16'h07E0);
    push(16'h001F);
    pixelValid = 1'b0;
    #1;
    check("t1_wvalid", 32'(wordValid), 32'd1);
    check("t1_wdata", wordData, 32'h35062D02);
    check("t1_wlast", 32'(wordLast), 32'd1);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_wvalid_clr", 32'(wordValid), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // Partial flush: six white pixels.
    pulse_start(20'd6);
    push(16'hFFFF);
    push(16'hFFFF);
    push(16'hFFFF);
    push(16'hFFFF);
    check("t2_w0_data", wordData, 32'h35353535);
    check("t2_w0_last", 32'(wordLast), 32'd0);
    push(16'hFFFF);
    push(16'hFFFF);
    pixelValid = 1'b0;
    tick();
    check("t2_w1_valid", 32'(wordValid), 32'd1);
    check("t2_w1_data", wordData, 32'h35350000);
    check("t2_w1_last", 32'(wordLast), 32'd1);
    tick();
    check("t2_done", 32'(done), 32'd1);
    tick();

    // Backpressure: downstream stalls 5 cycles after the first word.
    wordReady = 1'b0;
    pulse_start(20'd8);
    push(16'hFFFF);
    push(16'hF800);
    push(16'h07E0);
    push(16'h001F);
    check("t3_w0_data", wordData, 32'h35062D02);
    push(16'h001F);
    push(16'h07E0);
    push(16'hF800);
    pixelValid = 1'b1;
    pixelData  = 16'hFFFF;
    #1;
    check("t3_stall_ready", 32'(pixelReady), 32'd0);
    check("t3_stall_data", wordData, 32'h35062D02);
    tick();
    check("t3_stall_ready2", 32'(pixelReady), 32'd0);
    check("t3_stall_data2", wordData, 32'h35062D02);
    check("t3_stall_valid", 32'(wordValid), 32'd1);
    wordReady = 1'b1;
    #1;
    check("t3_release_ready", 32'(pixelReady), 32'd1);
    tick();
    pixelValid = 1'b0;
    check("t3_w1_valid", 32'(wordValid), 32'd1);
    check("t3_w1_data", wordData, 32'h022D0635);
    check("t3_w1_last", 32'(wordLast), 32'd1);
    tick();
    check("t3_done", 32'(done), 32'd1);
    tick();

    // Single pixel frame: blue lands in the top lane, low lanes zero.
    pulse_start(20'd1);
    push(16'h001F);
    pixelValid = 1'b0;
    tick();
    check("t4_data", wordData, 32'h02000000);
    check("t4_last", 32'(wordLast), 32'd1);
    tick();
    tick();

    // Zero-length frame.
    pulse_start(20'd0);
    #1;
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_done_c1", 32'(done), 32'd0);
    check("t5_wvalid_c1", 32'(wordValid), 32'd0);
    tick();
    check("t5_done_c2", 32'(done), 32'd1);
    check("t5_busy_c2", 32'(busy), 32'd0);
    check("t5_wvalid_c2", 32'(wordValid), 32'd0);
    tick();

    // Start while busy must not reload the count.
    pulse_start(20'd4);
    push(16'hFFFF);
    push(16'hFFFF);
    pixelValid = 1'b0;
    pulse_start(20'd5);
    push(16'hFFFF);
    push(16'h0000);
    pixelValid = 1'b0;
    #1;
    check("t6_data", wordData, 32'h35353500);
    check("t6_last", 32'(wordLast), 32'd1);
    check("t6_no_more", 32'(pixelReady), 32'd0);
    tick();
    check("t6_done", 32'(done), 32'd1);
    tick();

    // Mid-frame reset abandons the frame.
    pulse_start(20'd4);
    push(16'hFFFF);
    push(16'hFFFF);
    pixelValid = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_pixready", 32'(pixelReady), 32'd0);
    check("t7_wvalid", 32'(wordValid), 32'd0);
    check("t7_wdata", wordData, 32'h0);
    tick();
    nReset = 1'b1;
    tick();
    pulse_start(20'd4);
    push(16'h001F);
    push(16'h07E0);
    push(16'hF800);
    push(16'hFFFF);
    pixelValid = 1'b0;
    #1;
    check("t7_new_data", wordData, 32'h022D0635);
    check("t7_new_last", 32'(wordLast), 32'd1);
    tick();
    check("t7_new_done", 32'(done), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
